// File: rtl/l2_word_responder_pkg.sv
// Shared types for the L2 word responder: line/beat/word containers, the
// responder state encoding and the byte-lane merge helper.
package rv32i_types;

    localparam int OFFSET_BITS   = 5;
    localparam int TAG_BITS      = 27;
    localparam int LINE_BITS     = 256;
    localparam int BEAT_BITS     = 64;
    localparam int WORD_BITS     = 32;
    localparam int WORD_IDX_BITS = 3;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;
    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [TAG_BITS-1:0]  tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FILL,
        ST_RESPOND
    } resp_state_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic word_t merge_bytes(input word_t old_word,
                                          input word_t new_word,
                                          input logic [3:0] be);
        word_t result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_word_responder_if.sv
// Single-word L2 request port between the I/D arbiter (master) and the
// word responder (slave).
interface l2_word_responder_if;
    import rv32i_types::*;

    logic        l2_read;
    logic        l2_write;
    logic [31:0] l2_address;
    word_t       l2_wdata;
    logic [3:0]  l2_byte_enable;
    word_t       l2_rdata;
    logic        l2_resp;

    modport master (
        output l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable,
        input  l2_rdata, l2_resp
    );

    modport slave (
        input  l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable,
        output l2_rdata, l2_resp
    );

endinterface

// File: rtl/l2_line_buffer.sv
// One-line buffer: 256-bit data, tag, valid and dirty, with a byte-merged
// word write port (hits) and a full-beat write port (fills).
module l2_line_buffer
    import rv32i_types::*;
#(
    parameter int LINE_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          word_we,
    input  logic [WORD_IDX_BITS-1:0]      word_sel,
    input  word_t                         word_wdata,
    input  logic [3:0]                    word_be,
    input  logic                          beat_we,
    input  logic [$clog2(LINE_BEATS)-1:0] beat_sel,
    input  beat_t                         beat_wdata,
    input  logic                          fill_done,
    input  tag_t                          fill_tag,
    input  logic                          wb_done,
    output line_t                         line_data,
    output tag_t                          tag,
    output logic                          valid,
    output logic                          dirty
);

    // Line storage: word merges on write hits, whole beats during a fill.
    always_ff @(posedge clk) begin
        if (word_we) begin
            line_data[int'(word_sel)*WORD_BITS +: WORD_BITS] <=
                merge_bytes(line_data[int'(word_sel)*WORD_BITS +: WORD_BITS], word_wdata, word_be);
        end
        if (beat_we) begin
            line_data[int'(beat_sel)*BEAT_BITS +: BEAT_BITS] <= beat_wdata;
        end
    end

    // Tag is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag <= fill_tag;
        end
    end

    // Valid/dirty: a finished fill validates, a finished writeback cleans,
    // any write hit (even with no byte enabled) dirties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dirty <= 1'b0;
        end else begin
            if (fill_done) begin
                valid <= 1'b1;
            end
            if (wb_done) begin
                dirty <= 1'b0;
            end else if (word_we) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_word_responder.sv
// Memory-side end of the L2 request port: serves word reads/writes from a
// one-line buffer, writing back and refilling it over 64-bit pmem bursts.
module l2_word_responder
    import rv32i_types::*;
#(
    parameter int BEAT_WIDTH = 64,
    parameter int LINE_BEATS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2_word_responder_if.slave    l2,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [BEAT_WIDTH-1:0] pmem_wdata,
    input  logic [BEAT_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int              CNT_W     = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    resp_state_t              state;
    resp_state_t              state_next;
    logic [CNT_W-1:0]         cnt;
    logic                     last_beat;
    logic                     req;
    logic                     is_write;
    logic                     hit;
    tag_t                     req_tag;
    logic [WORD_IDX_BITS-1:0] word_sel;
    word_t                    sel_word;
    word_t                    rdata_q;
    line_t                    buf_line;
    tag_t                     buf_tag;
    logic                     buf_valid;
    logic                     buf_dirty;
    logic                     word_we;
    logic                     beat_we;
    logic                     fill_done;
    logic                     wb_done;
    logic                     capture;
    logic                     unused_addr_bits;

    assign req_tag          = l2.l2_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign word_sel         = l2.l2_address[OFFSET_BITS-1:2];
    assign unused_addr_bits = ^l2.l2_address[1:0];
    assign req              = l2.l2_read | l2.l2_write;
    assign is_write         = l2.l2_write;
    assign hit              = buf_valid && (buf_tag == req_tag);
    assign last_beat        = (cnt == LAST_BEAT);
    assign sel_word         = buf_line[int'(word_sel)*WORD_BITS +: WORD_BITS];

    assign l2.l2_resp  = (state == ST_RESPOND);
    assign l2.l2_rdata = rdata_q;

    l2_line_buffer #(
        .LINE_BEATS (LINE_BEATS)
    ) u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_we    (word_we),
        .word_sel   (word_sel),
        .word_wdata (l2.l2_wdata),
        .word_be    (l2.l2_byte_enable),
        .beat_we    (beat_we),
        .beat_sel   (cnt),
        .beat_wdata (pmem_rdata),
        .fill_done  (fill_done),
        .fill_tag   (req_tag),
        .wb_done    (wb_done),
        .line_data  (buf_line),
        .tag        (buf_tag),
        .valid      (buf_valid),
        .dirty      (buf_dirty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and buffer write strobes; pmem_resp is only honoured in bursts.
    always_comb begin
        state_next = state;
        word_we    = 1'b0;
        beat_we    = 1'b0;
        fill_done  = 1'b0;
        wb_done    = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_next = ST_RESPOND;
                        capture    = 1'b1;
                        word_we    = is_write;
                    end else if (buf_dirty) begin
                        state_next = ST_WRITEBACK;
                    end else begin
                        state_next = ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (pmem_resp && last_beat) begin
                    wb_done    = 1'b1;
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (pmem_resp) begin
                    beat_we = 1'b1;
                    if (last_beat) begin
                        fill_done  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Beat counter, advanced by each accepted pmem beat, wraps at line end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state == ST_WRITEBACK || state == ST_FILL) && pmem_resp) begin
            cnt <= last_beat ? '0 : cnt + 1'b1;
        end
    end

    // Response word captured on the hit cycle; writes return the merged value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= is_write ? merge_bytes(sel_word, l2.l2_wdata, l2.l2_byte_enable) : sel_word;
        end
    end

    // pmem burst outputs decoded from state so reset drops them immediately.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {buf_tag, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = buf_line[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, {OFFSET_BITS{1'b0}}};
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_word_responder.sv
// Directed bench for l2_word_responder with a small pmem memory model.
module tb_l2_word_responder;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata = 64'h0;
    logic        pmem_resp = 1'b0;

    l2_word_responder_if l2_bus();

    l2_word_responder #(
        .BEAT_WIDTH (64),
        .LINE_BEATS (4),
        .ADDR_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l2           (l2_bus),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          fills;
    int          wbs;
    int          overlap = 0;
    logic [31:0] fill_addr;
    logic [31:0] wb_addr;
    logic [63:0] mem [logic [28:0]];
    int          lat;
    logic [31:0] rd;

    always @(negedge clk) begin
        if (rst_n && l2_bus.l2_read && l2_bus.l2_write) begin
            failures++;
            $error("FAIL req_both observed=read&write expected=one");
        end
    end

    function automatic logic [63:0] mem_rd(input logic [28:0] idx);
        if (mem.exists(idx)) return mem[idx];
        return 64'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        tick();
        check(tag, l2_bus.l2_resp, 1'b0);
    endtask

    // Issue one request, serve pmem with the given accept pattern, return at the resp cycle.
    task automatic run_req(input logic rdq, input logic wrq, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input logic [15:0] pat,
                           output int lat_o, output logic [31:0] rdata_o);
        int          p;
        bit          got;
        logic [28:0] idx;
        l2_bus.l2_read        = rdq;
        l2_bus.l2_write       = wrq;
        l2_bus.l2_address     = addr;
        l2_bus.l2_wdata       = wd;
        l2_bus.l2_byte_enable = be;
        lat_o   = 1;
        rdata_o = 32'h0;
        p       = 0;
        got     = 1'b0;
        fills   = 0;
        wbs     = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            lat_o++;
            pmem_resp = 1'b0;
            if (l2_bus.l2_resp) begin
                got     = 1'b1;
                rdata_o = l2_bus.l2_rdata;
            end else if (pmem_read || pmem_write) begin
                if (pmem_read && pmem_write) overlap++;
                if (pat[p % 16]) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        wb_addr  = pmem_address;
                        idx      = pmem_address[31:3] + 29'(wbs);
                        mem[idx] = pmem_wdata;
                        wbs++;
                    end else begin
                        fill_addr  = pmem_address;
                        idx        = pmem_address[31:3] + 29'(fills);
                        pmem_rdata = mem_rd(idx);
                        fills++;
                    end
                end
                p++;
            end
        end
        check("resp_seen", got, 1'b1);
        l2_bus.l2_read  = 1'b0;
        l2_bus.l2_write = 1'b0;
        pmem_resp       = 1'b0;
    endtask

    initial begin
        l2_bus.l2_read        = 1'b0;
        l2_bus.l2_write       = 1'b0;
        l2_bus.l2_address     = 32'h0;
        l2_bus.l2_wdata       = 32'h0;
        l2_bus.l2_byte_enable = 4'h0;
        mem[29'h20] = 64'h1111111111111111;
        mem[29'h21] = 64'h2222222222222222;
        mem[29'h22] = 64'h3333333333333333;
        mem[29'h23] = 64'h4444444444444444;
        mem[29'h40] = 64'h5555555555555555;
        mem[29'h41] = 64'h6666666666666666;
        mem[29'h42] = 64'h7777777777777777;
        mem[29'h43] = 64'h8888888888888888;
        mem[29'h60] = 64'h0102030405060708;
        mem[29'h61] = 64'h1112131415161718;
        mem[29'h62] = 64'h2122232425262728;
        mem[29'h63] = 64'h3132333435363738;
        mem[29'h80] = 64'hA0A1A2A3A4A5A6A7;
        mem[29'h81] = 64'hB0B1B2B3B4B5B6B7;
        mem[29'h82] = 64'hC0C1C2C3C4C5C6C7;
        mem[29'h83] = 64'hD0D1D2D3D4D5D6D7;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_l2_resp", l2_bus.l2_resp, 1'b0);
        check("rst_l2_rdata", l2_bus.l2_rdata, 32'h0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // cold read: one clean fill
        run_req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("cold_rdata", rd, 32'h11111111);
        check("cold_fills", fills, 4);
        check("cold_wbs", wbs, 0);
        check("cold_fill_addr", fill_addr, 32'h0000_0100);
        idle_check("cold_resp_width");

        // write hit then read hit, no pmem traffic
        run_req(1'b0, 1'b1, 32'h0000_0108, 32'hDEADBEEF, 4'b0011, 16'hFFFF, lat, rd);
        check("wr_hit_rdata", rd, 32'h2222BEEF);
        check("wr_hit_lat", lat, 2);
        check("wr_hit_pmem", fills + wbs, 0);
        idle_check("wr_hit_resp_width");
        run_req(1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("rd_hit_rdata", rd, 32'h2222BEEF);
        check("rd_hit_lat", lat, 2);
        check("rd_hit_pmem", fills + wbs, 0);
        idle_check("rd_hit_resp_width");

        // dirty miss: writeback then fill
        run_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("dm_wbs", wbs, 4);
        check("dm_wb_addr", wb_addr, 32'h0000_0100);
        check("dm_wb_beat0", mem[29'h20], 64'h1111111111111111);
        check("dm_wb_beat1", mem[29'h21], 64'h222222222222BEEF);
        check("dm_fills", fills, 4);
        check("dm_fill_addr", fill_addr, 32'h0000_0200);
        check("dm_rdata", rd, 32'h55555555);
        idle_check("dm_resp_width");

        // fill with pmem_resp gaps 1,0,0,1,1,0,1
        run_req(1'b1, 1'b0, 32'h0000_030C, 32'h0, 4'h0, 16'hFFD9, lat, rd);
        check("gap_fills", fills, 4);
        check("gap_wbs", wbs, 0);
        check("gap_rdata", rd, 32'h11121314);
        idle_check("gap_resp_width");
        run_req(1'b1, 1'b0, 32'h0000_0318, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("gap_beat3", rd, 32'h35363738);
        check("gap_beat3_pmem", fills + wbs, 0);
        idle_check("gap_b3_resp_width");
        run_req(1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("gap_beat0", rd, 32'h01020304);
        idle_check("gap_b0_resp_width");

        // reset during beat 2 of a fill
        l2_bus.l2_read    = 1'b1;
        l2_bus.l2_address = 32'h0000_0404;
        tick();
        check("rf_pmem_read", pmem_read, 1'b1);
        check("rf_pmem_address", pmem_address, 32'h0000_0400);
        pmem_resp  = 1'b1;
        pmem_rdata = mem[29'h80];
        tick();
        pmem_rdata = mem[29'h81];
        tick();
        pmem_rdata = mem[29'h82];
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_async_read_drop", pmem_read, 1'b0);
        check("rf_async_addr_drop", pmem_address, 32'h0);
        pmem_resp         = 1'b0;
        l2_bus.l2_read    = 1'b0;
        l2_bus.l2_address = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rf_idle_after", pmem_read | pmem_write | l2_bus.l2_resp, 1'b0);
        run_req(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("rf_refetch_fills", fills, 4);
        check("rf_refetch_wbs", wbs, 0);
        check("rf_refetch_rdata", rd, 32'hA0A1A2A3);
        idle_check("rf_resp_width");

        // back-to-back I-read / D-write with no idle gap
        run_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("b2b_fill_rdata", rd, 32'h11111111);
        check("b2b_fill_wbs", wbs, 0);
        run_req(1'b0, 1'b1, 32'h0000_011C, 32'hCAFEF00D, 4'b1111, 16'hFFFF, lat, rd);
        check("b2b_wr_lat", lat, 3);
        check("b2b_wr_rdata", rd, 32'hCAFEF00D);
        run_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("b2b_rd_lat", lat, 3);
        check("b2b_rd_rdata", rd, 32'h11111111);
        run_req(1'b0, 1'b1, 32'h0000_011C, 32'h12345678, 4'b0000, 16'hFFFF, lat, rd);
        check("b2b_be0_lat", lat, 3);
        check("b2b_be0_rdata", rd, 32'hCAFEF00D);
        idle_check("b2b_resp_width");

        // writeback carries the full-word write; be=0 write still dirties
        run_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("wb2_wbs", wbs, 4);
        check("wb2_wb_addr", wb_addr, 32'h0000_0100);
        check("wb2_beat3", mem[29'h23], 64'hCAFEF00D44444444);
        check("wb2_rdata", rd, 32'h55555555);
        idle_check("wb2_resp_width");
        run_req(1'b0, 1'b1, 32'h0000_0204, 32'hFFFFFFFF, 4'b0000, 16'hFFFF, lat, rd);
        check("be0_lat", lat, 2);
        check("be0_rdata", rd, 32'h55555555);
        idle_check("be0_resp_width");
        run_req(1'b1, 1'b0, 32'h0000_030C, 32'h0, 4'h0, 16'hFFFF, lat, rd);
        check("be0_dirty_wbs", wbs, 4);
        check("be0_wb_addr", wb_addr, 32'h0000_0200);
        check("be0_wb_beat0", mem[29'h40], 64'h5555555555555555);
        check("be0_miss_rdata", rd, 32'h11121314);
        idle_check("be0_miss_resp_width");

        check("pmem_rd_wr_exclusive", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
